// File: rtl/pingpong_buffer_pkg.sv
// Shared types and helpers for the multi-bank ping-pong buffer.
package pingpong_buffer_pkg;

    localparam int unsigned MAX_BANKS = 4;

    // Committed-bank count, 0..MAX_BANKS inclusive.
    typedef logic [2:0] bank_cnt_t;

    function automatic int unsigned bytes_of(input int unsigned data_width);
        return data_width / 8;
    endfunction

    // Advance a bank pointer modulo num_banks (also correct for 3 banks).
    function automatic logic [1:0] next_ptr(input logic [1:0] ptr, input int unsigned num_banks);
        return (32'(ptr) == num_banks - 1) ? 2'd0 : ptr + 2'd1;
    endfunction

endpackage

// File: rtl/bank_ram_be.sv
// Simple dual-port RAM: byte-enable write, registered read with a valid flag.
module bank_ram_be
    import pingpong_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 128,
    parameter int unsigned AW         = $clog2(DEPTH),
    parameter int unsigned BYTES      = bytes_of(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [BYTES-1:0]      wr_strb,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < int'(BYTES); i++) begin
                if (wr_strb[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

endmodule

// File: rtl/pingpong_buffer.sv
// Multi-bank ping-pong buffer: producer fills and commits banks, consumer reads and releases.
module pingpong_buffer
    import pingpong_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned BUFFER_DEPTH = 64,
    parameter int unsigned ADDR_WIDTH   = $clog2(BUFFER_DEPTH),
    parameter int unsigned NUM_BANKS    = 2,
    parameter int unsigned BANK_W       = $clog2(NUM_BANKS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [ADDR_WIDTH-1:0]      wr_addr,
    input  logic [DATA_WIDTH/8-1:0]    wr_strb,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       wr_commit,
    output logic                       wr_ready,
    output logic [BANK_W-1:0]          wr_bank,
    input  logic                       rd_en,
    input  logic [ADDR_WIDTH-1:0]      rd_addr,
    input  logic                       rd_release,
    output logic                       rd_ready,
    output logic [BANK_W-1:0]          rd_bank,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       valid_out,
    output logic                       err
);

    localparam int unsigned BYTES  = bytes_of(DATA_WIDTH);
    localparam int unsigned FLAT_W = BANK_W + ADDR_WIDTH;
    localparam bank_cnt_t   FULL   = bank_cnt_t'(NUM_BANKS);

    logic [BANK_W-1:0] wp_q, wp_d, rp_q, rp_d;
    bank_cnt_t         full_cnt_q, full_cnt_d;
    logic              err_q, err_d;
    logic              wr_acc, commit_acc, rd_acc, rel_acc, proto_err;

    assign wr_ready = (full_cnt_q < FULL);
    assign rd_ready = (full_cnt_q != '0);
    assign wr_bank  = wp_q;
    assign rd_bank  = rp_q;
    assign err      = err_q;

    always_comb begin
        wr_acc     = rst && wr_en && wr_ready;
        commit_acc = wr_commit && wr_ready;
        rd_acc     = rst && rd_en && rd_ready;
        rel_acc    = rd_release && rd_ready;
        // Offending operations are simply not accepted above; only the flag records them.
        proto_err  = ((wr_en || wr_commit) && !wr_ready) || ((rd_en || rd_release) && !rd_ready);

        wp_d       = wp_q;
        rp_d       = rp_q;
        full_cnt_d = full_cnt_q;
        err_d      = err_q || proto_err;

        if (commit_acc) begin
            wp_d = BANK_W'(next_ptr(2'(wp_q), NUM_BANKS));
        end
        if (rel_acc) begin
            rp_d = BANK_W'(next_ptr(2'(rp_q), NUM_BANKS));
        end

        unique case ({commit_acc, rel_acc})
            2'b10:   full_cnt_d = full_cnt_q + bank_cnt_t'(1);
            2'b01:   full_cnt_d = full_cnt_q - bank_cnt_t'(1);
            default: full_cnt_d = full_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wp_q       <= '0;
            rp_q       <= '0;
            full_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            full_cnt_q <= full_cnt_d;
            err_q      <= err_d;
        end
    end

    // Same-cycle write/read use the pre-advance pointers, so data lands in the old bank.
    bank_ram_be #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (NUM_BANKS * BUFFER_DEPTH),
        .AW         (FLAT_W),
        .BYTES      (BYTES)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_acc),
        .wr_addr  ({wp_q, wr_addr}),
        .wr_strb  (wr_strb),
        .wr_data  (data_in),
        .rd_en    (rd_acc),
        .rd_addr  ({rp_q, rd_addr}),
        .rd_data  (data_out),
        .rd_valid (valid_out)
    );

endmodule

// File: tb/tb_pingpong_buffer.sv
// Bench for pingpong_buffer: directed table, hand sequences (2 and 3 banks), random vs model.
module tb_pingpong_buffer;

    localparam int NB    = 2;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 2-bank instance
    logic        rst = 1'b0, wr_en = 1'b0, wr_commit = 1'b0, rd_en = 1'b0, rd_release = 1'b0;
    logic [5:0]  wr_addr = '0, rd_addr = '0;
    logic [7:0]  wr_strb = '0;
    logic [63:0] data_in = '0;
    logic        wr_ready, rd_ready, valid_out, err;
    logic [0:0]  wr_bank, rd_bank;
    logic [63:0] data_out;

    // 3-bank instance
    logic        rst_3 = 1'b0, wr_en_3 = 1'b0, wr_commit_3 = 1'b0, rd_en_3 = 1'b0;
    logic        rd_release_3 = 1'b0;
    logic [5:0]  wr_addr_3 = '0, rd_addr_3 = '0;
    logic [7:0]  wr_strb_3 = '0;
    logic [63:0] data_in_3 = '0;
    logic        wr_ready_3, rd_ready_3, valid_out_3, err_3;
    logic [1:0]  wr_bank_3, rd_bank_3;
    logic [63:0] data_out_3;

    pingpong_buffer #(.NUM_BANKS(2)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_strb(wr_strb),
        .data_in(data_in), .wr_commit(wr_commit), .wr_ready(wr_ready), .wr_bank(wr_bank),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_release(rd_release), .rd_ready(rd_ready),
        .rd_bank(rd_bank), .data_out(data_out), .valid_out(valid_out), .err(err)
    );

    pingpong_buffer #(.NUM_BANKS(3)) dut3 (
        .clk(clk), .rst(rst_3), .wr_en(wr_en_3), .wr_addr(wr_addr_3), .wr_strb(wr_strb_3),
        .data_in(data_in_3), .wr_commit(wr_commit_3), .wr_ready(wr_ready_3),
        .wr_bank(wr_bank_3), .rd_en(rd_en_3), .rd_addr(rd_addr_3), .rd_release(rd_release_3),
        .rd_ready(rd_ready_3), .rd_bank(rd_bank_3), .data_out(data_out_3),
        .valid_out(valid_out_3), .err(err_3)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: banks as a flat word array, counters as plain integers.
    logic [63:0] m_mem [NB*DEPTH];
    bit          m_known [NB*DEPTH];
    int          m_wp, m_rp, m_cnt;
    logic        m_err, m_valid;
    logic [63:0] m_data;
    bit          m_dknown;

    task automatic model_update();
        int  idx;
        bit  wr_ok, rd_ok;
        if (!rst) begin
            m_wp = 0; m_rp = 0; m_cnt = 0; m_err = 1'b0;
            m_valid = 1'b0; m_data = '0; m_dknown = 1'b1;
            return;
        end
        wr_ok = (m_cnt < NB);
        rd_ok = (m_cnt > 0);
        if (((wr_en || wr_commit) && !wr_ok) || ((rd_en || rd_release) && !rd_ok)) m_err = 1'b1;
        m_valid = rd_en && rd_ok;
        if (m_valid) begin
            idx      = m_rp * DEPTH + int'(rd_addr);
            m_data   = m_mem[idx];
            m_dknown = m_known[idx];
        end
        if (wr_en && wr_ok) begin
            idx = m_wp * DEPTH + int'(wr_addr);
            for (int b = 0; b < 8; b++) begin
                if (wr_strb[b]) m_mem[idx][8*b +: 8] = data_in[8*b +: 8];
            end
            if (wr_strb == 8'hFF) m_known[idx] = 1'b1;
        end
        if (wr_commit && wr_ok) begin
            m_cnt++;
            m_wp = (m_wp + 1) % NB;
        end
        if (rd_release && rd_ok) begin
            m_cnt--;
            m_rp = (m_rp + 1) % NB;
        end
    endtask

    task automatic model_check();
        chk("wr_ready", 64'(wr_ready), 64'(m_cnt < NB));
        chk("rd_ready", 64'(rd_ready), 64'(m_cnt != 0));
        chk("wr_bank", 64'(wr_bank), 64'(m_wp));
        chk("rd_bank", 64'(rd_bank), 64'(m_rp));
        chk("valid_out", 64'(valid_out), 64'(m_valid));
        chk("err", 64'(err), 64'(m_err));
        if (m_dknown) chk("data_out", data_out, m_data);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        model_check();
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_commit = 1'b0; rd_en = 1'b0; rd_release = 1'b0;
        wr_strb = '0; wr_addr = '0; rd_addr = '0; data_in = '0;
    endtask

    task automatic step3();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [5:0]  wa;
        logic [7:0]  ws;
        logic [63:0] wd;
        logic        wc;
        logic        re;
        logic [5:0]  ra;
        logic        rl;
        logic [4:0]  xf;   // {wr_ready, rd_ready, wr_bank, rd_bank, valid_out}
        logic [63:0] xd;
        logic        xe;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [5:0] wa, input logic [7:0] ws,
                                input logic [63:0] wd, input logic wc, input logic re,
                                input logic [5:0] ra, input logic rl, input logic [4:0] xf,
                                input logic [63:0] xd, input logic xe);
        vec_t v;
        v.we = we; v.wa = wa; v.ws = ws; v.wd = wd; v.wc = wc;
        v.re = re; v.ra = ra; v.rl = rl; v.xf = xf; v.xd = xd; v.xe = xe;
        return v;
    endfunction

    vec_t tbl [15];

    initial begin
        // Starts with bank 0 committed (data=addr), wp=1, rp=0, last read gave 5.
        tbl[0]  = mk(1'b0, 6'd0,  8'h00, 64'h0, 1'b0, 1'b0, 6'd0,  1'b1, 5'b10110, 64'd5, 1'b0);
        tbl[1]  = mk(1'b1, 6'd3,  8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 6'd0, 1'b0,
                     5'b10110, 64'd5, 1'b0);
        tbl[2]  = mk(1'b1, 6'd3,  8'h0F, 64'h0, 1'b0, 1'b0, 6'd0,  1'b0, 5'b10110, 64'd5, 1'b0);
        tbl[3]  = mk(1'b0, 6'd0,  8'h00, 64'h0, 1'b1, 1'b0, 6'd0,  1'b0, 5'b11010, 64'd5, 1'b0);
        tbl[4]  = mk(1'b0, 6'd0,  8'h00, 64'h0, 1'b0, 1'b1, 6'd3,  1'b0, 5'b11011,
                     64'hFFFF_FFFF_0000_0000, 1'b0);
        tbl[5]  = mk(1'b0, 6'd0,  8'h00, 64'h0, 1'b0, 1'b0, 6'd0,  1'b1, 5'b10000,
                     64'hFFFF_FFFF_0000_0000, 1'b0);
        tbl[6]  = mk(1'b0, 6'd0,  8'h00, 64'h0, 1'b1, 1'b0, 6'd0,  1'b0, 5'b11100,
                     64'hFFFF_FFFF_0000_0000, 1'b0);
        tbl[7]  = mk(1'b0, 6'd0,  8'h00, 64'h0, 1'b1, 1'b0, 6'd0,  1'b0, 5'b01000,
                     64'hFFFF_FFFF_0000_0000, 1'b0);
        tbl[8]  = mk(1'b1, 6'd7,  8'hFF, 64'hDEAD, 1'b0, 1'b0, 6'd0, 1'b0, 5'b01000,
                     64'hFFFF_FFFF_0000_0000, 1'b1);
        tbl[9]  = mk(1'b0, 6'd0,  8'h00, 64'h0, 1'b0, 1'b1, 6'd7,  1'b0, 5'b01001, 64'd7, 1'b1);
        tbl[10] = mk(1'b0, 6'd0,  8'h00, 64'h0, 1'b0, 1'b0, 6'd0,  1'b1, 5'b11010, 64'd7, 1'b1);
        tbl[11] = mk(1'b1, 6'd63, 8'hFF, 64'hAB, 1'b1, 1'b0, 6'd0,  1'b0, 5'b01110, 64'd7, 1'b1);
        tbl[12] = mk(1'b0, 6'd0,  8'h00, 64'h0, 1'b0, 1'b0, 6'd0,  1'b1, 5'b11100, 64'd7, 1'b1);
        tbl[13] = mk(1'b0, 6'd0,  8'h00, 64'h0, 1'b0, 1'b1, 6'd63, 1'b0, 5'b11101, 64'hAB, 1'b1);
        tbl[14] = mk(1'b0, 6'd0,  8'h00, 64'h0, 1'b1, 1'b1, 6'd3,  1'b1, 5'b11011, 64'd3, 1'b1);

        // Reset
        idle();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("reset_flags", 64'({wr_ready, rd_ready, wr_bank, rd_bank, valid_out, err}),
            64'(6'b100000));

        // Fill bank 0 with data=addr and commit
        for (int a = 0; a < DEPTH; a++) begin
            wr_en = 1'b1; wr_addr = 6'(a); wr_strb = 8'hFF; data_in = 64'(a);
            step();
        end
        idle();
        wr_commit = 1'b1;
        step();
        idle();
        chk("fill_wr_bank", 64'(wr_bank), 64'd1);
        chk("fill_rd_ready", 64'(rd_ready), 64'd1);
        rd_en = 1'b1; rd_addr = 6'd5;
        step();
        idle();
        chk("read5_valid", 64'(valid_out), 64'd1);
        chk("read5_data", data_out, 64'd5);

        // Directed table
        for (int i = 0; i < 15; i++) begin
            wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_strb = tbl[i].ws; data_in = tbl[i].wd;
            wr_commit = tbl[i].wc; rd_en = tbl[i].re; rd_addr = tbl[i].ra;
            rd_release = tbl[i].rl;
            step();
            chk($sformatf("tbl%0d_flags", i),
                64'({wr_ready, rd_ready, wr_bank, rd_bank, valid_out}), 64'(tbl[i].xf));
            chk($sformatf("tbl%0d_data", i), data_out, tbl[i].xd);
            chk($sformatf("tbl%0d_err", i), 64'(err), 64'(tbl[i].xe));
        end
        idle();

        // Reset the cycle after a read: in-flight data is discarded
        rd_en = 1'b1; rd_addr = 6'd3;
        step();
        idle();
        rst = 1'b0;
        step();
        chk("rst_after_rd", 64'({valid_out, wr_ready, rd_ready, err}), 64'(4'b0100));
        chk("rst_after_rd_data", data_out, 64'd0);
        rd_en = 1'b1;
        step();
        chk("rd_during_rst", 64'(valid_out), 64'd0);
        rst = 1'b1;
        idle();

        // Randomized run against the model, with occasional resets
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 299) != 0);
            wr_en      = 1'($urandom_range(0, 1));
            wr_addr    = 6'($urandom);
            wr_strb    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            data_in    = {$urandom, $urandom};
            wr_commit  = ($urandom_range(0, 7) == 0);
            rd_en      = 1'($urandom_range(0, 1));
            rd_addr    = 6'($urandom);
            rd_release = ($urandom_range(0, 7) == 0);
            step();
        end
        rst = 1'b1;
        idle();

        // 3-bank instance: pointer wrap, data through each bank, read underflow
        rst_3 = 1'b0;
        step3();
        rst_3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("nb3_wr_bank%0d", i), 64'(wr_bank_3), 64'(i % 3));
            wr_en_3 = 1'b1; wr_addr_3 = 6'd1; wr_strb_3 = 8'hFF; data_in_3 = 64'(100 + i);
            wr_commit_3 = 1'b1;
            step3();
            wr_en_3 = 1'b0; wr_commit_3 = 1'b0;
            chk($sformatf("nb3_rd_bank%0d", i), 64'(rd_bank_3), 64'(i % 3));
            rd_en_3 = 1'b1; rd_addr_3 = 6'd1;
            step3();
            rd_en_3 = 1'b0;
            chk($sformatf("nb3_data%0d", i), data_out_3, 64'(100 + i));
            chk($sformatf("nb3_valid%0d", i), 64'(valid_out_3), 64'd1);
            rd_release_3 = 1'b1;
            step3();
            rd_release_3 = 1'b0;
            chk($sformatf("nb3_empty%0d", i), 64'(rd_ready_3), 64'd0);
        end
        chk("nb3_err_clean", 64'(err_3), 64'd0);
        rd_en_3 = 1'b1; rd_addr_3 = 6'd1;
        step3();
        rd_en_3 = 1'b0;
        chk("nb3_underflow_valid", 64'(valid_out_3), 64'd0);
        chk("nb3_underflow_err", 64'(err_3), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pingpong_buffer.md
Name: pingpong_buffer

Overview:
Multi-bank double/quad buffer that decouples a producer (weight or activation loader) from a consumer (GEMM PE array) in the w4a8 datapath.
- Generalises the single-bank buffer: configurable bank count, per-byte write strobes and bank-ownership handshake.
- Read latency is a registered 1 cycle.
- Producer fills a bank and commits it; consumer reads the committed bank at random addresses and releases it.

Parameters:
DATA_WIDTH, 64, word width in bits; must be a multiple of 8.
BUFFER_DEPTH, 64, words per bank; must be a power of 2.
ADDR_WIDTH, $clog2(BUFFER_DEPTH), word address width within a bank.
NUM_BANKS, 2, number of banks; legal range 2..4.
BANK_W, $clog2(NUM_BANKS), bank index width (derived).

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  synchronous, active-low reset.
wr_en  in  1  write request for the word at wr_addr in the producer bank.
wr_addr  in  ADDR_WIDTH  write word address.
wr_strb  in  DATA_WIDTH/8  byte enables; bit i enables data_in[8i+7:8i].
data_in  in  DATA_WIDTH  write data.
wr_commit  in  1  producer bank complete; hand it to the consumer.
wr_ready  out  1  a free bank is owned by the producer.
wr_bank  out  BANK_W  index of the producer bank.
rd_en  in  1  read request from the consumer bank.
rd_addr  in  ADDR_WIDTH  read word address.
rd_release  in  1  consumer finished; free the consumer bank.
rd_ready  out  1  at least one committed bank is available.
rd_bank  out  BANK_W  index of the consumer bank.
data_out  out  DATA_WIDTH  read data, registered.
valid_out  out  1  data_out valid this cycle.
err  out  1  sticky protocol-error flag.

Behaviour:
- Storage: NUM_BANKS*BUFFER_DEPTH words. Physical index = {bank, addr}. Memory contents are not reset.
- Control state:
  - wp: producer bank pointer.
  - rp: consumer bank pointer.
  - full_cnt: committed banks, range 0..NUM_BANKS.
- Flags: wr_ready = (full_cnt < NUM_BANKS); rd_ready = (full_cnt != 0); wr_bank = wp; rd_bank = rp.
- Reset (rst==0 at posedge): wp=0, rp=0, full_cnt=0, data_out=0, valid_out=0, err=0. Any in-flight read is discarded, so valid_out=0 the cycle after reset.
- Write, accepted when wr_en && wr_ready:
  - Bytes with wr_strb=1 are updated at {wp, wr_addr}; other bytes are kept.
  - wr_strb=0 with wr_en=1 is a legal no-op.
- Commit, when wr_commit && wr_ready:
  - full_cnt+1 and wp <= (wp+1) mod NUM_BANKS.
  - A write in the same cycle lands in the old wp bank before the hand-over.
- Read, when rd_en && rd_ready:
  - data_out <= mem[{rp, rd_addr}] at the next edge; valid_out=1 in that cycle.
  - Otherwise valid_out=0 and data_out holds its previous value.
- Release, when rd_release && rd_ready:
  - full_cnt-1 and rp <= (rp+1) mod NUM_BANKS.
  - A read in the same cycle uses the old rp bank.
- Commit and release in the same cycle: full_cnt unchanged; both pointers advance.
- Pointer wrap: with non-power-of-2 NUM_BANKS (3), the pointer returns from NUM_BANKS-1 to 0.
- Ownership is exclusive: when full_cnt==NUM_BANKS, wp==rp but the bank belongs to the consumer. No read/write collision on one bank is possible, so no bypass path exists.
- Protocol errors set err=1 (sticky until reset); the offending operation is dropped, no state change:
  - wr_en or wr_commit while !wr_ready;
  - rd_en or rd_release while !rd_ready.

Decomposition:
- Package pingpong_buffer_pkg holds: the bank-state count type, the BYTES = DATA_WIDTH/8 derivation function, and a next-pointer mod-NUM_BANKS function.
- One sub-module, bank_ram_be: simple dual-port RAM with byte-enable write and registered read plus valid, instantiated once over the flat {bank, addr} space.
- Pointer/count logic stays in pingpong_buffer.

Test Plan:
- Reset, then fill bank 0 at addr 0..63 with data=addr, full strobes, commit -> wr_bank=1, rd_ready=1, full_cnt=1; rd_en addr 5 -> data_out=5, valid_out=1 exactly 1 cycle later.
- Write 64'hFFFF_FFFF_FFFF_FFFF at addr 3, then 64'h0 with wr_strb=8'h0F, commit, read addr 3 -> data_out=64'hFFFF_FFFF_0000_0000.
- NUM_BANKS=2: commit twice without release -> wr_ready=0; wr_en -> err=1 and bank 0 data unchanged; release -> wr_ready=1, wr_bank=0.
- Same-cycle wr_en+wr_commit at addr 63 data 0xAB -> data lands in the old bank (readable at addr 63 of rd_bank); simultaneous commit+release with full_cnt=1 -> full_cnt stays 1, wp and rp both advance.
- NUM_BANKS=3: 4 commit/release rounds -> wr_bank sequence 0,1,2,0; rd_en while rd_ready=0 -> valid_out=0 next cycle, err=1.
- Assert rst=0 in the cycle after rd_en -> valid_out=0, data_out=0, wr_ready=1, rd_ready=0.
